// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slice.
// Holds the FSM state encoding and default frame width.
package spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

endpackage

// File: rtl/sck_tick_gen.sv
// Half-period divider for the SPI serial clock.
// tick is high on the last clk of each CLK_DIV-cycle interval.
module sck_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TC);

  // free-running count, restarted by the FSM on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (reload || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, fixed-length frames, MSB first.
// Define SPI_MASTER_CS_EN to add the active-low cs_n output.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] d,
  output logic [FRAME_BITS-1:0] q,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi
`ifdef SPI_MASTER_CS_EN
  ,
  output logic                  cs_n
`endif
);

  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BW-1:0] LAST = BW'(FRAME_BITS - 1);

  spi_state_t state, nxt;
  logic [FRAME_BITS-1:0] tx;
  logic [FRAME_BITS-1:0] rx;
  logic [BW-1:0] bitcnt;
  logic tick;
  logic reload;
  logic last;

  assign last   = (bitcnt == LAST);
  assign sdo    = tx[FRAME_BITS-1];
  assign reload = (nxt != state) || (state == IDLE);

  sck_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .reload(reload),
    .tick  (tick)
  );

  // next-state decode; timed states advance on the divider tick
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = SETUP;
      SETUP: if (tick) nxt = HIGH;
      HIGH:  if (tick) nxt = last ? DONE : LOW;
      LOW:   if (tick) nxt = HIGH;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state register plus registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= (nxt != IDLE);
      done  <= (nxt == DONE);
    end
  end

  // sck edges, tx shift on falling edge, rx sample on rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck    <= 1'b0;
      tx     <= '0;
      rx     <= '0;
      bitcnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        tx     <= d;
        bitcnt <= '0;
      end
      if (state != HIGH && nxt == HIGH) begin
        sck <= 1'b1;
        rx  <= {rx[FRAME_BITS-2:0], sdi};
      end
      if (state == HIGH && nxt != HIGH) begin
        sck <= 1'b0;
        if (!last) begin
          tx     <= {tx[FRAME_BITS-2:0], 1'b0};
          bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end

  // q only changes when a complete frame has been received
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (nxt == DONE)
      q <= rx;
  end

`ifdef SPI_MASTER_CS_EN
  // select low for the whole frame, SETUP through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cs_n <= 1'b1;
    else
      cs_n <= (nxt == IDLE);
  end
`endif

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sck half-period in clk cycles; legal values 1..255.
REQ-002 SHALL have parameter FRAME_BITS, default 32: bits per transaction.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1: request a transaction, sampled only in IDLE.
REQ-006 SHALL have port d, input, FRAME_BITS: word to transmit, MSB first.
REQ-007 SHALL have port q, output, FRAME_BITS: word received on sdi.
REQ-008 SHALL have port busy, output, 1: high while a transaction is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port sck, output, 1: serial clock, idle low.
REQ-011 SHALL have port sdo, output, 1: master-out serial data.
REQ-012 SHALL have port sdi, input, 1: master-in serial data.

Function
REQ-013 SHALL use SPI mode 0: sck idle low; sdo changes only on sck falling edges or at SETUP entry; sdi sampled on sck rising edges. This matches the FPGA slave, which shifts on posedge and counts on negedge.
REQ-014 SHALL implement the FSM IDLE -> SETUP -> HIGH <-> LOW -> DONE -> IDLE.
REQ-015 IDLE behaviour: on a clk edge with start=1, SHALL latch d into the tx shift register, drive sdo=d[FRAME_BITS-1], clear the bit counter and enter SETUP.
REQ-016 SETUP behaviour: SHALL hold sck=0 for CLK_DIV cycles, then enter HIGH.
REQ-017 HIGH behaviour: SHALL drive sck=1 for CLK_DIV cycles and shift sdi into q's rx shift register LSB on HIGH entry (the rising edge).
REQ-018 Exit from HIGH on the last bit (bit counter = FRAME_BITS-1): SHALL drive sck=0 and enter DONE.
REQ-019 Exit from HIGH on any other bit: SHALL drive sck=0, shift the tx register left so sdo presents the next bit, increment the bit counter, and enter LOW.
REQ-020 LOW behaviour: SHALL hold sck=0 for CLK_DIV cycles, then enter HIGH.
REQ-021 DONE behaviour: done=1 and q updated with the full rx word for exactly one cycle; SHALL then return to IDLE. q SHALL hold its value until the next DONE.
REQ-022 Timing: the sck rising edge k (k=0..FRAME_BITS-1) SHALL occur (1+2k)*CLK_DIV cycles after the accepting edge; done SHALL be high 2*FRAME_BITS*CLK_DIV cycles after it (256 for the defaults).
REQ-023 SHALL emit exactly FRAME_BITS sck pulses per transaction, never partial frames, because the slave's bit counter is free-running modulo 32.
REQ-024 busy SHALL be high in SETUP, HIGH, LOW and DONE, and low in IDLE.
REQ-025 start while busy SHALL be ignored, with no queuing. start held high SHALL begin a new transaction on the cycle after DONE (back-to-back).
REQ-026 Changes to d after acceptance SHALL have no effect on the current frame.
REQ-027 The divider counter SHALL be ceil(log2(CLK_DIV+1)) bits wide and reload on every state change. The bit counter SHALL be ceil(log2(FRAME_BITS)) bits wide, with no wrap beyond FRAME_BITS-1.

Reset
REQ-028 On reset, SHALL immediately (asynchronously) force state=IDLE, sck=0, sdo=0, busy=0, done=0, q=0 and all counters to 0.
REQ-029 Reset mid-transaction SHALL abort the frame with no done pulse. The first start after reset release SHALL begin a clean frame.

Configuration
REQ-030 Macro SPI_MASTER_CS_EN defined: SHALL add output cs_n (1 bit, active low), driven low from SETUP entry through DONE and high in IDLE and during reset.
REQ-031 Macro SPI_MASTER_CS_EN undefined: port cs_n SHALL be absent and all other behaviour identical.

Structure
REQ-032 Package spi_pkg SHALL hold the FSM state enum typedef (IDLE, SETUP, HIGH, LOW, DONE) and the constant FRAME_BITS_DEFAULT=32.
REQ-033 Sub-module sck_tick_gen SHALL provide a CLK_DIV half-period terminal-count tick, with a reload input driven by the FSM. All other logic is in spi_master.

Verification
REQ-034 Basic exchange: CLK_DIV=4, d=32'hA5C3_0F81, slave model returns 32'h1234_5678 -> sdo bit stream equals d MSB first; q=32'h1234_5678; done high exactly at cycle 256.
REQ-035 Loopback with CLK_DIV=1 (sdi tied to sdo), d=32'hFFFF_0000 -> q=32'hFFFF_0000; sck period 2 clk; 32 rising edges counted.
REQ-036 start pulsed 5 times during a transfer -> one frame only; busy stays high; single done pulse.
REQ-037 Back-to-back: start held high for 2 frames -> second SETUP begins the cycle after done; exactly 64 sck pulses total.
REQ-038 Reset asserted at rising edge 10 -> sck=0, sdo=0, busy=0 within the same cycle; no done; the next frame is correct.
REQ-039 With SPI_MASTER_CS_EN defined -> cs_n falls on the accepting edge+1 and rises after DONE. Without the macro -> the bench compiles with no cs_n port.
